// File: rtl/fifo_skew_sched.sv
// fifo_skew_sched: drains rows_p row FIFOs into a systolic array edge with diagonal skew,
//   so row r starts r steps after row 0. One start_i pulse streams len_p elements per row.
// Latency: zero-cycle data path. Strobes and data are combinational from state, t and fifo_valid_i.
// Backpressure: the wavefront advances in lockstep. Any empty active row stalls every row.
// Ports:
//   clk_i, reset_i (sync, active-high), start_i  : control; start_i is honoured only when idle
//   busy_o, done_o, stall_o                      : status (busy in RUN/DONE, one-cycle done pulse)
//   fifo_valid_i/fifo_data_i/fifo_yumi_o         : row FIFO read side (yumi only when valid)
//   array_valid_o/array_data_o                   : skewed elements into the array, row r at [r*width_p +: width_p]
module fifo_skew_sched #(
  parameter int rows_p  = 4,
  parameter int width_p = 8,
  parameter int len_p   = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        stall_o,
  input  logic [rows_p-1:0]           fifo_valid_i,
  input  logic [rows_p*width_p-1:0]   fifo_data_i,
  output logic [rows_p-1:0]           fifo_yumi_o,
  output logic [rows_p-1:0]           array_valid_o,
  output logic [rows_p*width_p-1:0]   array_data_o
);

  localparam int tw_lp = $clog2(len_p + rows_p);
  // Final step index: the last row's last element.
  localparam logic [tw_lp-1:0] last_t_lp = tw_lp'(len_p + rows_p - 2);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_run  = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  logic [1:0]        state;
  logic [tw_lp-1:0]  t;
  logic [rows_p-1:0] active;
  logic              run;
  logic              go;

  // Row r carries data during steps r .. r+len_p-1 of the wavefront.
  always_comb begin
    active = '0;
    for (int r = 0; r < rows_p; r++) begin
      if ((int'(t) >= r) && (int'(t) < r + len_p)) begin
        active[r] = 1'b1;
      end
    end
  end

  assign run = (state == st_run);
  // A step fires only when every active row has an element; inactive rows are don't-care.
  assign go  = &(fifo_valid_i | ~active);

  assign stall_o       = run & ~go;
  assign fifo_yumi_o   = (run && go) ? active : '0;
  assign array_valid_o = fifo_yumi_o;
  assign busy_o        = (state == st_run) || (state == st_done);
  assign done_o        = (state == st_done);

  // Idle and stalled rows present zero data so the array edge never sees stale values.
  always_comb begin
    array_data_o = '0;
    for (int r = 0; r < rows_p; r++) begin
      if (fifo_yumi_o[r]) begin
        array_data_o[r*width_p +: width_p] = fifo_data_i[r*width_p +: width_p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= st_idle;
      t     <= '0;
    end else begin
      case (state)
        st_idle: begin
          if (start_i) begin
            state <= st_run;
            t     <= '0;
          end
        end
        st_run: begin
          if (go) begin
            if (t == last_t_lp) begin
              state <= st_done;
              t     <= '0;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
        st_done: state <= st_idle;
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_skew_sched.sv
// tb_fifo_skew_sched: exercises fifo_skew_sched against a queue-based model of the row FIFOs
//   and of the skewed wavefront schedule; a second 1x1 instance covers the degenerate shape.
// Status words are packed as {busy, done, stall, yumi, valid, data}.
module tb_fifo_skew_sched;

  localparam int R = 4;
  localparam int W = 8;
  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, start, busy, done, stall;
  logic [R-1:0]     fifo_valid, yumi, avalid;
  logic [R*W-1:0]   fifo_data, adata;

  logic             s_start, s_valid, s_yumi, s_avalid, s_busy, s_done, s_stall;
  logic [W-1:0]     s_data, s_adata;

  fifo_skew_sched #(.rows_p(R), .width_p(W), .len_p(L)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .busy_o(busy), .done_o(done), .stall_o(stall),
    .fifo_valid_i(fifo_valid), .fifo_data_i(fifo_data), .fifo_yumi_o(yumi),
    .array_valid_o(avalid), .array_data_o(adata)
  );

  fifo_skew_sched #(.rows_p(1), .width_p(W), .len_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(s_start),
    .busy_o(s_busy), .done_o(s_done), .stall_o(s_stall),
    .fifo_valid_i(s_valid), .fifo_data_i(s_data), .fifo_yumi_o(s_yumi),
    .array_valid_o(s_avalid), .array_data_o(s_adata)
  );

  // Model: queues stand in for the row FIFOs; hide[r] forces a row to look empty.
  // mode 0 = waiting for start, 1 = streaming step k, 2 = tile finished (done pulse).
  logic [W-1:0] q [R][$];
  logic [R-1:0] hide;
  int           mode, k;
  int           checks, passes;

  task automatic clear_q();
    for (int r = 0; r < R; r++) q[r].delete();
  endtask

  task automatic fill(input int r, input int n);
    for (int i = 0; i < n; i++) q[r].push_back(W'($urandom));
  endtask

  // One clock cycle: drive inputs from the model, sample DUT mid-cycle, compute the
  // expected word from the schedule rules, then advance the model past the edge.
  task automatic tick(input bit st, input bit rst, output logic [42:0] obs, output logic [42:0] exp);
    logic [R-1:0]   v, act, ev;
    logic [R*W-1:0] d, ed;
    bit             all_ready;
    v = '0; d = '0; ed = '0; act = '0;
    for (int r = 0; r < R; r++) begin
      if (q[r].size() > 0) begin
        d[r*W +: W] = q[r][0];
        if (!hide[r]) v[r] = 1'b1;
      end
    end
    fifo_valid = v; fifo_data = d; start = st; reset = rst;
    #2;
    if (mode == 1) begin
      for (int r = 0; r < R; r++) if (r <= k && k < r + L) act[r] = 1'b1;
    end
    all_ready = ((act & ~v) == '0);
    ev = (mode == 1 && all_ready) ? act : '0;
    for (int r = 0; r < R; r++) if (ev[r]) ed[r*W +: W] = q[r][0];
    exp = {mode != 0, mode == 2, mode == 1 && !all_ready, ev, ev, ed};
    obs = {busy, done, stall, yumi, avalid, adata};
    @(posedge clk); #1;
    for (int r = 0; r < R; r++) if (ev[r]) void'(q[r].pop_front());
    if (rst) begin
      mode = 0; k = 0;
    end else if (mode == 0) begin
      if (st) begin mode = 1; k = 0; end
    end else if (mode == 1) begin
      if (all_ready) begin
        if (k == L + R - 2) mode = 2;
        else k++;
      end
    end else begin
      mode = 0;
    end
  endtask

  task automatic test_reset();
    logic [42:0] obs, exp;
    clear_q(); fill(0, 2); fill(1, 2); fill(2, 2); fill(3, 2); hide = '0;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, obs, exp);
      checks++;
      if (obs !== 43'd0) $display("FAIL reset cyc %0d got %h exp %h", i, obs, 43'd0);
      else passes++;
    end
  endtask

  task automatic test_basic();
    logic [42:0] obs, exp;
    logic [3:0]  pat [0:6];
    pat[0] = 4'h1; pat[1] = 4'h3; pat[2] = 4'h7; pat[3] = 4'hF;
    pat[4] = 4'hE; pat[5] = 4'hC; pat[6] = 4'h8;
    clear_q(); hide = '0;
    for (int r = 0; r < R; r++) fill(r, L);
    for (int i = 0; i < 10; i++) begin
      tick(i == 0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp) $display("FAIL basic_model cyc %0d got %h exp %h", i, obs, exp);
      else passes++;
      if (i >= 1 && i <= 7) begin
        checks++;
        if (obs[35:32] !== pat[i-1]) $display("FAIL basic_pattern cyc %0d got %h exp %h", i, obs[35:32], pat[i-1]);
        else passes++;
      end
      checks++;
      if (obs[41] !== 1'(i == 8)) $display("FAIL basic_done cyc %0d got %b exp %b", i, obs[41], i == 8);
      else passes++;
      checks++;
      if (obs[42] !== 1'(i >= 1 && i <= 8)) $display("FAIL basic_busy cyc %0d got %b exp %b", i, obs[42], i >= 1 && i <= 8);
      else passes++;
    end
  endtask

  task automatic test_stall();
    logic [42:0] obs, exp;
    int stall_cnt, done_cyc;
    stall_cnt = 0; done_cyc = -1;
    clear_q();
    for (int r = 0; r < R; r++) fill(r, L);
    for (int i = 0; i < 12; i++) begin
      hide = (i == 4 || i == 5) ? 4'b0100 : 4'b0000;
      tick(i == 0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp) $display("FAIL stall_model cyc %0d got %h exp %h", i, obs, exp);
      else passes++;
      if (obs[40]) begin
        stall_cnt++;
        checks++;
        if (obs[39:36] !== 4'h0) $display("FAIL stall_yumi cyc %0d got %h exp 0", i, obs[39:36]);
        else passes++;
      end
      if (obs[41]) done_cyc = i;
    end
    hide = '0;
    checks++;
    if (stall_cnt !== 2) $display("FAIL stall_count got %0d exp 2", stall_cnt);
    else passes++;
    checks++;
    if (done_cyc !== 10) $display("FAIL stall_done_cycle got %0d exp 10", done_cyc);
    else passes++;
  endtask

  task automatic test_late_row();
    logic [42:0] obs, exp;
    int stall_cnt, done_cyc, row3;
    stall_cnt = 0; done_cyc = -1; row3 = 0;
    clear_q(); hide = '0;
    for (int r = 0; r < 3; r++) fill(r, L);
    for (int i = 0; i < 12; i++) begin
      if (i == 6) fill(3, L);
      tick(i == 0, 1'b0, obs, exp);
      checks++;
      if (obs !== exp) $display("FAIL late_model cyc %0d got %h exp %h", i, obs, exp);
      else passes++;
      checks++;
      if ((obs[39:36] & ~fifo_valid) !== 4'h0) $display("FAIL late_empty_pop cyc %0d got %h exp 0", i, obs[39:36] & ~fifo_valid);
      else passes++;
      stall_cnt += int'(obs[40]);
      row3 += int'(obs[39]);
      if (obs[41]) done_cyc = i;
    end
    checks++;
    if (stall_cnt !== 2 || done_cyc !== 10 || row3 !== L)
      $display("FAIL late_summary got stalls %0d done %0d row3 %0d exp 2 10 %0d", stall_cnt, done_cyc, row3, L);
    else passes++;
  endtask

  task automatic test_start_ignored();
    logic [42:0] obs, exp;
    int cnt [R];
    for (int r = 0; r < R; r++) cnt[r] = 0;
    clear_q(); hide = '0;
    for (int r = 0; r < R; r++) fill(r, L + 2);
    for (int i = 0; i < 13; i++) begin
      tick(i == 0 || i == 3 || i == 8 || i == 9, i == 11, obs, exp);
      checks++;
      if (obs !== exp) $display("FAIL restart_model cyc %0d got %h exp %h", i, obs, exp);
      else passes++;
      if (i <= 9) for (int r = 0; r < R; r++) cnt[r] += int'(obs[36+r]);
      if (i == 9 || i == 10) begin
        checks++;
        if (obs[42] !== 1'(i == 10)) $display("FAIL restart_busy cyc %0d got %b exp %b", i, obs[42], i == 10);
        else passes++;
      end
    end
    for (int r = 0; r < R; r++) begin
      checks++;
      if (cnt[r] !== L) $display("FAIL restart_yumi_count row %0d got %0d exp %0d", r, cnt[r], L);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic [42:0] obs, exp;
    int cnt [R];
    int done_cyc;
    done_cyc = -1;
    for (int r = 0; r < R; r++) cnt[r] = 0;
    clear_q(); hide = '0;
    for (int r = 0; r < R; r++) fill(r, 2 * L);
    for (int i = 0; i < 16; i++) begin
      tick(i == 0 || i == 5, i == 3, obs, exp);
      checks++;
      if (obs !== exp) $display("FAIL rstmid_model cyc %0d got %h exp %h", i, obs, exp);
      else passes++;
      if (i == 4) begin
        checks++;
        if (obs !== 43'd0) $display("FAIL rstmid_idle cyc 4 got %h exp 0", obs);
        else passes++;
      end
      if (i >= 5) for (int r = 0; r < R; r++) cnt[r] += int'(obs[36+r]);
      if (obs[41]) done_cyc = i;
    end
    checks++;
    if (done_cyc !== 13 || cnt[0] !== L || cnt[1] !== L || cnt[2] !== L || cnt[3] !== L)
      $display("FAIL rstmid_tile got done %0d counts %0d %0d %0d %0d exp 13 and %0d each",
               done_cyc, cnt[0], cnt[1], cnt[2], cnt[3], L);
    else passes++;
  endtask

  task automatic test_random();
    logic [42:0] obs, exp;
    int cnt [R];
    int extra [R];
    int n;
    for (int tile = 0; tile < 8; tile++) begin
      clear_q();
      for (int r = 0; r < R; r++) begin
        cnt[r] = 0;
        extra[r] = $urandom_range(0, 2);
        fill(r, L + extra[r]);
      end
      n = 0;
      do begin
        hide = R'($urandom) & R'($urandom);
        tick(n == 0 || (mode != 0 && $urandom_range(0, 3) == 0), 1'b0, obs, exp);
        checks++;
        if (obs !== exp) $display("FAIL random_model tile %0d cyc %0d got %h exp %h", tile, n, obs, exp);
        else passes++;
        for (int r = 0; r < R; r++) cnt[r] += int'(obs[36+r]);
        n++;
      end while (mode != 0 && n < 300);
      checks++;
      if (n >= 300) $display("FAIL random_timeout tile %0d got %0d cycles exp under 300", tile, n);
      else passes++;
      for (int r = 0; r < R; r++) begin
        checks++;
        if (cnt[r] !== L || q[r].size() !== extra[r])
          $display("FAIL random_count tile %0d row %0d got %0d pops %0d left exp %0d pops %0d left",
                   tile, r, cnt[r], q[r].size(), L, extra[r]);
        else passes++;
      end
    end
    hide = '0;
  endtask

  task automatic test_single_row();
    logic [12:0] obs, exp [0:3];
    exp[0] = 13'd0;
    exp[1] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A};
    exp[2] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    exp[3] = 13'd0;
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_start = (i == 0);
      s_valid = 1'b1;
      s_data  = (i <= 1) ? 8'h5A : 8'hC3;
      #2;
      obs = {s_busy, s_done, s_stall, s_yumi, s_avalid, s_adata};
      checks++;
      if (obs !== exp[i]) $display("FAIL single_row cyc %0d got %h exp %h", i, obs, exp[i]);
      else passes++;
      @(posedge clk); #1;
    end
    s_start = 1'b0; s_valid = 1'b0;
  endtask

  initial begin
    checks = 0; passes = 0; mode = 0; k = 0; hide = '0;
    reset = 1'b1; start = 1'b0; fifo_valid = '0; fifo_data = '0;
    s_start = 1'b0; s_valid = 1'b0; s_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_stall();
    test_late_row();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_single_row();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
